// File: rtl/avalon_aes_regfile.sv
// Avalon-MM register file for the AES conduit: key/ciphertext registers,
// start/done handshake with the core, result capture and timeout.
module avalon_aes_regfile #(
  parameter int unsigned TIMEOUT = 2048,
  parameter int unsigned CNT_W   = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         avs_chipselect,
  input  logic         avs_read,
  input  logic         avs_write,
  input  logic [3:0]   avs_address,
  input  logic [3:0]   avs_byteenable,
  input  logic [31:0]  avs_writedata,
  output logic [31:0]  avs_readdata,
  output logic [127:0] aes_key,
  output logic [127:0] aes_msg_enc,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_msg_dec,
  output logic [31:0]  export_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      key_q [4];
  logic [31:0]      key_d [4];
  logic [31:0]      msg_q [4];
  logic [31:0]      msg_d [4];
  logic [31:0]      dec_q [4];
  logic [31:0]      dec_d [4];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             tout_q, tout_d;
  logic             aes_start_q, aes_start_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      rd_word;

  logic wr_en, rd_en, wr_start, start_set, start_clr;

  assign wr_en     = avs_chipselect & avs_write;
  assign rd_en     = avs_chipselect & avs_read;
  assign wr_start  = wr_en & (avs_address == 4'd14) & avs_byteenable[0];
  assign start_set = wr_start & avs_writedata[0];
  assign start_clr = wr_start & ~avs_writedata[0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Register writes and FSM share one process so RUN can lock key/msg writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    done_d  = done_q;
    tout_d  = tout_q;
    rdata_d = rdata_q;
    for (int unsigned i = 0; i < 4; i++) begin
      key_d[i] = key_q[i];
      msg_d[i] = msg_q[i];
      dec_d[i] = dec_q[i];
    end

    if (wr_en && state_q != ST_RUN) begin
      case (avs_address[3:2])
        2'd0: key_d[avs_address[1:0]] =
                merge_bytes(key_q[avs_address[1:0]], avs_writedata, avs_byteenable);
        2'd1: msg_d[avs_address[1:0]] =
                merge_bytes(msg_q[avs_address[1:0]], avs_writedata, avs_byteenable);
        default: ;
      endcase
    end

    if (wr_start) start_d = avs_writedata[0];

    case (state_q)
      ST_IDLE: begin
        if (start_set) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          done_d  = 1'b0;
          tout_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // Abort outranks a same-cycle aes_done; the count is frozen as-is.
        if (start_clr) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (aes_done) begin
            dec_d[0] = aes_msg_dec[127:96];
            dec_d[1] = aes_msg_dec[95:64];
            dec_d[2] = aes_msg_dec[63:32];
            dec_d[3] = aes_msg_dec[31:0];
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
            done_d  = 1'b1;
            tout_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (start_clr) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
          tout_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    aes_start_d = (state_d == ST_RUN);

    if (rd_en) rdata_d = rd_word;
  end

  always_comb begin
    rd_word = '0;
    case (avs_address)
      4'd0, 4'd1, 4'd2, 4'd3:   rd_word = key_q[avs_address[1:0]];
      4'd4, 4'd5, 4'd6, 4'd7:   rd_word = msg_q[avs_address[1:0]];
      4'd8, 4'd9, 4'd10, 4'd11: rd_word = dec_q[avs_address[1:0]];
      4'd12:                    rd_word = {30'd0, state_q};
      4'd13:                    rd_word = 32'(cnt_q);
      4'd14:                    rd_word = {31'd0, start_q};
      4'd15:                    rd_word = {30'd0, tout_q, done_q};
      default:                  rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      tout_q      <= 1'b0;
      aes_start_q <= 1'b0;
      rdata_q     <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        key_q[i] <= '0;
        msg_q[i] <= '0;
        dec_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      done_q      <= done_d;
      tout_q      <= tout_d;
      aes_start_q <= aes_start_d;
      rdata_q     <= rdata_d;
      for (int unsigned i = 0; i < 4; i++) begin
        key_q[i] <= key_d[i];
        msg_q[i] <= msg_d[i];
        dec_q[i] <= dec_d[i];
      end
    end
  end

  assign avs_readdata = rdata_q;
  assign aes_start    = aes_start_q;
  assign aes_key      = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign aes_msg_enc  = {msg_q[0], msg_q[1], msg_q[2], msg_q[3]};
  assign export_data  = {key_q[0][31:16], key_q[3][15:0]};

endmodule

// File: tb/tb_avalon_aes_regfile.sv
// Directed bench for avalon_aes_regfile: register access, done, timeout,
// abort racing done, and mid-run reset.
module tb_avalon_aes_regfile;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         avs_chipselect, avs_read, avs_write;
  logic [3:0]   avs_address, avs_byteenable;
  logic [31:0]  avs_writedata, avs_readdata;
  logic [127:0] aes_key, aes_msg_enc, aes_msg_dec;
  logic         aes_start, aes_done;
  logic [31:0]  export_data;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] rd;

  avalon_aes_regfile #(.TIMEOUT(16), .CNT_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs_chipselect (avs_chipselect),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_address    (avs_address),
    .avs_byteenable (avs_byteenable),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .aes_key        (aes_key),
    .aes_msg_enc    (aes_msg_enc),
    .aes_start      (aes_start),
    .aes_done       (aes_done),
    .aes_msg_dec    (aes_msg_dec),
    .export_data    (export_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    avs_chipselect = 1'b1; avs_write = 1'b1;
    avs_address = a; avs_writedata = d; avs_byteenable = be;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    @(posedge clk); #1;
    bus_idle();
    d = avs_readdata;
  endtask

  task automatic bus_rw(input logic [3:0] a, input logic [31:0] wd, output logic [31:0] d);
    @(negedge clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b1;
    avs_address = a; avs_writedata = wd; avs_byteenable = 4'hF;
    @(posedge clk); #1;
    bus_idle();
    d = avs_readdata;
  endtask

  initial begin
    bus_idle();
    avs_address = '0; avs_byteenable = '0; avs_writedata = '0;
    aes_done = 1'b0; aes_msg_dec = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: reset state
    for (int i = 0; i < 16; i++) begin
      bus_read(4'(i), rd);
      check($sformatf("reset_r%0d", i), rd, 128'd0);
    end
    check("reset_start", aes_start, 0);
    check("reset_export", export_data, 0);

    // 2: byte-lane writes, export, read-during-write
    bus_write(4'd0, 32'hDEADBEEF, 4'b0011);
    bus_write(4'd3, 32'h12345678, 4'hF);
    bus_read(4'd0, rd);
    check("be_r0", rd, 32'h0000BEEF);
    check("export", export_data, 32'h00005678);
    bus_write(4'd1, 32'hCAFEF00D, 4'hF);
    bus_rw(4'd1, 32'h01020304, rd);
    check("rw_old", rd, 32'hCAFEF00D);
    bus_read(4'd1, rd);
    check("rw_new", rd, 32'h01020304);
    check("key", aes_key, 128'h0000BEEF_01020304_00000000_12345678);

    // 3: normal operation, done 5 cycles after start
    bus_write(4'd4, 32'h11111111, 4'hF);
    check("msg_enc", aes_msg_enc[127:96], 32'h11111111);
    bus_write(4'd14, 32'h1, 4'hF);
    check("run_start", aes_start, 1);
    repeat (4) @(posedge clk);
    #1;
    aes_done = 1'b1;
    aes_msg_dec = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    check("start_before_done", aes_start, 1);
    @(posedge clk); #1;
    aes_done = 1'b0;
    aes_msg_dec = '0;
    check("start_after_done", aes_start, 0);
    bus_read(4'd8,  rd); check("dec_r8",  rd, 32'h00112233);
    bus_read(4'd9,  rd); check("dec_r9",  rd, 32'h44556677);
    bus_read(4'd10, rd); check("dec_r10", rd, 32'h8899AABB);
    bus_read(4'd11, rd); check("dec_r11", rd, 32'hCCDDEEFF);
    bus_read(4'd15, rd); check("done_r15", rd, 32'h1);
    bus_read(4'd13, rd); check("cnt_r13", rd, 32'd5);
    bus_read(4'd12, rd); check("state_done", rd, 32'd2);
    bus_write(4'd14, 32'h1, 4'hF);
    bus_read(4'd12, rd); check("restart_ignored", rd, 32'd2);
    bus_write(4'd14, 32'h0, 4'hF);
    bus_read(4'd12, rd); check("state_idle", rd, 32'd0);
    bus_read(4'd15, rd); check("r15_cleared", rd, 32'd0);

    // 4: timeout after 16 RUN cycles
    bus_write(4'd14, 32'h1, 4'hF);
    repeat (15) @(posedge clk);
    #1 check("tout_pre_start", aes_start, 1);
    @(posedge clk); #1;
    check("tout_start_low", aes_start, 0);
    bus_read(4'd15, rd); check("tout_r15", rd, 32'd3);
    bus_read(4'd12, rd); check("tout_state", rd, 32'd2);
    bus_read(4'd8,  rd); check("tout_r8", rd, 32'h00112233);
    bus_read(4'd13, rd); check("tout_cnt", rd, 32'd16);
    bus_write(4'd14, 32'h0, 4'hF);

    // 5: locked msg write in RUN, abort racing done
    bus_write(4'd14, 32'h1, 4'hF);
    bus_write(4'd4, 32'hAAAAAAAA, 4'hF);
    aes_done = 1'b1;
    aes_msg_dec = 128'hFEDCBA98_76543210_0F0F0F0F_F0F0F0F0;
    bus_write(4'd14, 32'h0, 4'hF);
    aes_done = 1'b0;
    check("abort_start", aes_start, 0);
    bus_read(4'd4,  rd); check("abort_r4", rd, 32'h11111111);
    bus_read(4'd12, rd); check("abort_state", rd, 32'd0);
    bus_read(4'd15, rd); check("abort_r15", rd, 32'd0);
    bus_read(4'd8,  rd); check("abort_r8", rd, 32'h00112233);

    // 6: reset mid-run
    bus_write(4'd14, 32'h1, 4'hF);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rst_start", aes_start, 0);
    check("rst_export", export_data, 0);
    check("rst_key", aes_key, 128'd0);
    for (int i = 0; i < 16; i++) begin
      bus_read(4'(i), rd);
      check($sformatf("rst_r%0d", i), rd, 128'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
